// File: rtl/ecn_output_collector_pkg.sv
// Shared widths, round size and FSM encoding for the ECN output collector.
package ecn_output_collector_pkg;

    localparam int unsigned DefCounterWidth = 4;
    localparam int unsigned DefLlrWidth     = 5;
    localparam int unsigned DefQWidth       = 6;
    localparam int unsigned NOut            = 2 ** (DefCounterWidth + 1);

    localparam logic [DefLlrWidth:0] MaxLlr = '1;

    typedef enum logic [1:0] {
        StClear,
        StCollect,
        StDrain,
        StRelease
    } state_e;

endpackage

// File: rtl/ecn_output_collector_q_seen_table.sv
// One bit per GF symbol: combinational read of the current bit, set at the clock edge,
// whole table cleared in a single cycle.
module ecn_output_collector_q_seen_table #(
    parameter int unsigned Q_Width = 6
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    input  logic           set_en,
    input  logic [Q_Width:0] q,
    output logic           hit
);

    logic [2**(Q_Width+1)-1:0] seen;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen <= '0;
        end else if (clr) begin
            seen <= '0;
        end else if (set_en) begin
            seen[q] <= 1'b1;
        end
    end

    // Read-before-set: a symbol written this cycle is visible from the next cycle on.
    assign hit = seen[q];

endmodule

// File: rtl/ecn_output_collector.sv
// Keeps the first (lowest-LLR) occurrence of each symbol from the sorted ECN stream and drains
// N_OUT unique entries downstream. Optional macro ECN_COLLECT_NORM_EN stores LLRs relative to the
// first stored LLR of the round.
module ecn_output_collector
    import ecn_output_collector_pkg::*;
#(
    parameter int unsigned Counter_Width = DefCounterWidth,
    parameter int unsigned LLR_Width     = DefLlrWidth,
    parameter int unsigned Q_Width       = DefQWidth
) (
    input  logic               clk,
    input  logic               force_reset_n,
    input  logic               in_valid,
    input  logic [LLR_Width:0] in_llr,
    input  logic [Q_Width:0]   in_q,
    output logic               receivable,
    output logic               full,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LLR_Width:0] out_llr,
    output logic [Q_Width:0]   out_q,
    output logic               out_last
);

    localparam int unsigned NumOut = 2 ** (Counter_Width + 1);
    localparam logic [Counter_Width+1:0] WrOne = 1;
    localparam logic [Counter_Width:0]   RdOne = 1;

    state_e                 state;
    logic [Counter_Width+1:0] wr_cnt;
    logic [Counter_Width:0]   rd_cnt;
    logic [Counter_Width:0]   rd_next;
    logic [Counter_Width:0]   wr_idx;
    logic                     seen_hit;
    logic                     accept;
    logic [LLR_Width:0]       wr_llr;

    logic [LLR_Width:0] llr_mem [NumOut];
    logic [Q_Width:0]   q_mem   [NumOut];

    assign wr_idx  = wr_cnt[Counter_Width:0];
    assign rd_next = rd_cnt + RdOne;
    assign accept  = (state == StCollect) && in_valid && !seen_hit;

    ecn_output_collector_q_seen_table #(
        .Q_Width (Q_Width)
    ) u_q_seen_table (
        .clk    (clk),
        .rst_n  (force_reset_n),
        .clr    (state == StClear),
        .set_en (accept),
        .q      (in_q),
        .hit    (seen_hit)
    );

`ifdef ECN_COLLECT_NORM_EN
    logic [LLR_Width:0] base;

    always_ff @(posedge clk or negedge force_reset_n) begin
        if (!force_reset_n) begin
            base <= '0;
        end else if (accept && (wr_cnt == '0)) begin
            base <= in_llr;
        end
    end

    // Sorted stream guarantees in_llr >= base, so the difference never wraps.
    assign wr_llr = (wr_cnt == '0) ? '0 : in_llr - base;
`else
    assign wr_llr = in_llr;
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            llr_mem[wr_idx] <= wr_llr;
            q_mem[wr_idx]   <= in_q;
        end
    end

    always_ff @(posedge clk or negedge force_reset_n) begin
        if (!force_reset_n) begin
            state      <= StClear;
            receivable <= 1'b0;
            full       <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_llr    <= '0;
            out_q      <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
        end else begin
            unique case (state)
                StClear: begin
                    wr_cnt     <= '0;
                    rd_cnt     <= '0;
                    receivable <= 1'b1;
                    state      <= StCollect;
                end
                StCollect: begin
                    if (accept) begin
                        wr_cnt     <= wr_cnt + WrOne;
                        receivable <= 1'b0;
                        // Last slot written: present entry 0 on the same edge full rises.
                        if (&wr_idx) begin
                            full      <= 1'b1;
                            state     <= StDrain;
                            out_valid <= 1'b1;
                            out_llr   <= llr_mem[0];
                            out_q     <= q_mem[0];
                            out_last  <= 1'b0;
                            rd_cnt    <= '0;
                        end
                    end
                end
                StDrain: begin
                    if (out_valid && out_ready) begin
                        if (&rd_cnt) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= StRelease;
                        end else begin
                            rd_cnt   <= rd_next;
                            out_llr  <= llr_mem[rd_next];
                            out_q    <= q_mem[rd_next];
                            out_last <= &rd_next;
                        end
                    end
                end
                StRelease: begin
                    // Hold full until upstream has visibly stopped emitting.
                    if (!in_valid) begin
                        full  <= 1'b0;
                        state <= StClear;
                    end
                end
                default: state <= StClear;
            endcase
        end
    end

endmodule
